muldiv_issue_ctrl: RTL and testbench

- Sequences the iterative multiply/divide unit that sits beside the EX-stage ALU.
- Accepts one mul/div from ID/EX and starts the unit. Counts the unit's latency, then requests the shared WB register-file write port for the result.
- Stalls the front end on three hazards: RAW on the pending destination, WAW on the pending destination, and a structural conflict when a second mul/div arrives while the unit is occupied.
- Stall outputs use the same PC_write / IFID_write / mux_ctrl convention as the load-use stall logic. Top level ANDs PC_write and IFID_write and ORs mux_ctrl with that logic.

---
 rtl/muldiv_issue_ctrl_if.sv | 25 ++
 rtl/muldiv_issue_ctrl.sv | 136 +++++++++++++
 tb/tb_muldiv_issue_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_issue_ctrl_if.sv
// Handshake bundle between the mul/div issue controller,
// the iterative mul/div unit and the shared WB write port.
interface muldiv_issue_ctrl_if;
    logic       md_start;
    logic       md_busy;
    logic       md_wb_req;
    logic [4:0] md_wb_rd;
    logic       wb_ack;

    modport master (
        output md_start,
        output md_busy,
        output md_wb_req,
        output md_wb_rd,
        input  wb_ack
    );

    modport slave (
        input  md_start,
        input  md_busy,
        input  md_wb_req,
        input  md_wb_rd,
        output wb_ack
    );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// Issue/latency sequencer for the iterative mul/div unit, with
// RAW/WAW/structural front-end stall generation and a stall counter.
module muldiv_issue_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32,
    parameter int unsigned CNT_W   = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [4:0]                 IFID_rs,
    input  logic [4:0]                 IFID_rt,
    input  logic [4:0]                 IFID_rd,
    input  logic                       IFID_regwrite,
    input  logic                       IFID_md,
    input  logic                       IDEX_md_valid,
    input  logic                       IDEX_md_op,
    input  logic [4:0]                 IDEX_rd,
    input  logic                       ex_flush,
    muldiv_issue_ctrl_if.master        md,
    output logic                       PC_write,
    output logic                       IFID_write,
    output logic                       mux_ctrl,
    output logic [15:0]                stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_WB
    } state_e;

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [4:0]         pend_rd_q;
    logic               busy_q;
    logic               wb_req_q;
    logic [4:0]         wb_rd_q;
    logic [15:0]        stall_cnt_q;
    logic [15:0]        stall_cnt_d;

    logic               issue;
    logic               pend_valid;
    logic [4:0]         pend_cur;
    logic               raw;
    logic               waw;
    logic               strct;
    logic               stall;

    assign issue = IDEX_md_valid & ~ex_flush & (state_q == S_IDLE);

    // The issuing op is visible to hazard checks in its own issue cycle.
    assign pend_valid = ((state_q != S_IDLE) & (pend_rd_q != 5'd0))
                      | (issue & (IDEX_rd != 5'd0));
    assign pend_cur   = issue ? IDEX_rd : pend_rd_q;

    assign raw   = pend_valid & ((IFID_rs == pend_cur) | (IFID_rt == pend_cur));
    assign waw   = pend_valid & IFID_regwrite & (IFID_rd == pend_cur);
    assign strct = IFID_md & (busy_q | issue);
    assign stall = raw | waw | strct;

    assign PC_write   = ~stall;
    assign IFID_write = ~stall;
    assign mux_ctrl   = stall;

    assign md.md_start  = issue;
    assign md.md_busy   = busy_q;
    assign md.md_wb_req = wb_req_q;
    assign md.md_wb_rd  = wb_rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_rd_q <= '0;
            busy_q    <= 1'b0;
            wb_req_q  <= 1'b0;
            wb_rd_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        state_q   <= S_BUSY;
                        cnt_q     <= IDEX_md_op ? DIV_CNT : MUL_CNT;
                        pend_rd_q <= IDEX_rd;
                        busy_q    <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (pend_rd_q != 5'd0) begin
                        state_q  <= S_WB;
                        wb_req_q <= 1'b1;
                        wb_rd_q  <= pend_rd_q;
                    end else begin
                        // r0 destination: result is dropped silently
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_WB: begin
                    if (md.wb_ack) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        wb_req_q <= 1'b0;
                        wb_rd_q  <= '0;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    wb_req_q <= 1'b0;
                    wb_rd_q  <= '0;
                end
            endcase
        end
    end

    assign stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF))
                       ? stall_cnt_q + 16'd1
                       : stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Self-checking bench for muldiv_issue_ctrl: cycle-level behavioural
// model plus directed literal checks and randomized traffic.
module tb_muldiv_issue_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  IFID_rs, IFID_rt, IFID_rd;
    logic        IFID_regwrite, IFID_md;
    logic        IDEX_md_valid, IDEX_md_op;
    logic [4:0]  IDEX_rd;
    logic        ex_flush;
    logic        wb_ack;
    logic        PC_write, IFID_write, mux_ctrl;
    logic [15:0] stall_cnt;

    muldiv_issue_ctrl_if mif ();
    assign mif.wb_ack = wb_ack;

    muldiv_issue_ctrl #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT),
        .CNT_W  (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .IFID_rs      (IFID_rs),
        .IFID_rt      (IFID_rt),
        .IFID_rd      (IFID_rd),
        .IFID_regwrite(IFID_regwrite),
        .IFID_md      (IFID_md),
        .IDEX_md_valid(IDEX_md_valid),
        .IDEX_md_op   (IDEX_md_op),
        .IDEX_rd      (IDEX_rd),
        .ex_flush     (ex_flush),
        .md           (mif),
        .PC_write     (PC_write),
        .IFID_write   (IFID_write),
        .mux_ctrl     (mux_ctrl),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: an op is "active" from issue until it leaves the unit.
    bit         m_act = 1'b0;
    logic [4:0] m_rd;
    int         m_lat, m_start;
    int         cyc = 0;
    int         m_stalls = 0;

    bit         e_issue, e_wb, e_stall;
    logic [4:0] e_pend;
    int         e_sc;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            e_issue = IDEX_md_valid && !ex_flush && !m_act;
            e_wb    = m_act && (m_rd != 0) && (cyc >= m_start + m_lat + 1);
            e_pend  = e_issue ? IDEX_rd : (m_act ? m_rd : 5'd0);
            e_stall = ((e_pend != 0) &&
                       (IFID_rs == e_pend || IFID_rt == e_pend ||
                        (IFID_regwrite && IFID_rd == e_pend)))
                    || (IFID_md && (m_act || e_issue));
            e_sc    = (m_stalls > 65535) ? 65535 : m_stalls;

            chk("md_start",   mif.md_start,  e_issue);
            chk("md_busy",    mif.md_busy,   m_act);
            chk("md_wb_req",  mif.md_wb_req, e_wb);
            chk("md_wb_rd",   mif.md_wb_rd,  e_wb ? m_rd : 5'd0);
            chk("PC_write",   PC_write,      !e_stall);
            chk("IFID_write", IFID_write,    !e_stall);
            chk("mux_ctrl",   mux_ctrl,      e_stall);
            chk("stall_cnt",  stall_cnt,     e_sc);

            if (!rst && IDEX_md_valid && !ex_flush) begin
                n_chk++;
                assert (!mif.md_busy) else begin
                    n_fail++;
                    $display("FAIL md_valid_while_busy cycle %0d", cyc);
                end
            end

            if (rst) begin
                m_act    = 1'b0;
                m_stalls = 0;
            end else begin
                if (e_stall) m_stalls++;
                if (e_issue) begin
                    m_act   = 1'b1;
                    m_rd    = IDEX_rd;
                    m_lat   = IDEX_md_op ? DIV_LAT : MUL_LAT;
                    m_start = cyc;
                end else if (m_act) begin
                    if (m_rd == 0 && cyc == m_start + m_lat) m_act = 1'b0;
                    else if (e_wb && wb_ack) m_act = 1'b0;
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic quiet();
        IFID_rs = 0; IFID_rt = 0; IFID_rd = 0;
        IFID_regwrite = 0; IFID_md = 0;
        IDEX_md_valid = 0; IDEX_md_op = 0; IDEX_rd = 0;
        ex_flush = 0; wb_ack = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        IDEX_md_valid = 0;
        wb_ack = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            at_neg();
            if (!mif.md_busy) done = 1'b1;
            tick();
        end
        chk("wait_idle_timeout", done, 1'b1);
        wb_ack = 1'b0;
    endtask

    initial begin
        quiet();
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        rst = 1'b0;

        at_neg();
        chk("rst_busy",   mif.md_busy,   0);
        chk("rst_wbreq",  mif.md_wb_req, 0);
        chk("rst_wbrd",   mif.md_wb_rd,  0);
        chk("rst_stall",  {PC_write, IFID_write, mux_ctrl}, 3'b110);
        chk("rst_cnt",    stall_cnt,     0);
        tick();

        // multiply latency, unrelated operands
        IFID_rs = 1; IFID_rt = 2; IFID_rd = 3; IFID_regwrite = 1;
        for (int c = 0; c <= 8; c++) begin
            IDEX_md_valid = (c == 0);
            IDEX_md_op = 0; IDEX_rd = 5;
            wb_ack = (c == 7);
            at_neg();
            if (c == 0) chk("mul_start", mif.md_start, 1);
            if (c >= 1 && c <= 4)
                chk("mul_busy", {mif.md_busy, mif.md_wb_req}, 2'b10);
            if (c >= 5 && c <= 7)
                chk("mul_wb", {mif.md_wb_req, mif.md_wb_rd}, {1'b1, 5'd5});
            if (c == 8)
                chk("mul_idle", {mif.md_busy, mif.md_wb_req}, 2'b00);
            chk("mul_nostall", PC_write, 1);
            tick();
        end

        // RAW on divide destination r9
        quiet();
        do_reset();
        IFID_rs = 9;
        for (int c = 0; c <= 34; c++) begin
            IDEX_md_valid = (c == 0);
            IDEX_md_op = 1; IDEX_rd = 9;
            wb_ack = (c == 33);
            at_neg();
            if (c <= 33)
                chk("raw_stall", {PC_write, IFID_write, mux_ctrl}, 3'b001);
            else
                chk("raw_release", {PC_write, IFID_write, mux_ctrl}, 3'b110);
            if (c == 33)
                chk("raw_wb", {mif.md_wb_req, mif.md_wb_rd}, {1'b1, 5'd9});
            if (c == 34) chk("raw_stall_cnt", stall_cnt, 34);
            tick();
        end

        // structural and WAW while busy
        quiet();
        IFID_rs = 1; IFID_rt = 2; IFID_rd = 3; IFID_regwrite = 1;
        for (int c = 0; c <= 4; c++) begin
            IDEX_md_valid = (c == 0); IDEX_md_op = 0; IDEX_rd = 7;
            IFID_md = (c == 1);
            IFID_rd = (c == 2 || c == 4) ? 5'd7 : (c == 3 ? 5'd0 : 5'd3);
            IFID_regwrite = (c != 4);
            at_neg();
            chk("sw_mux", mux_ctrl, (c == 1 || c == 2));
            tick();
        end
        wait_idle();

        // flushed issue, then r0 destination
        quiet();
        IFID_rs = 5;
        IDEX_md_valid = 1; ex_flush = 1; IDEX_rd = 5;
        at_neg();
        chk("flush_start", mif.md_start, 0);
        chk("flush_nostall", PC_write, 1);
        tick();
        IDEX_md_valid = 0; ex_flush = 0;
        at_neg();
        chk("flush_idle", mif.md_busy, 0);
        tick();
        IFID_rs = 0;
        for (int c = 0; c <= 5; c++) begin
            IDEX_md_valid = (c == 0); IDEX_md_op = 0; IDEX_rd = 0;
            at_neg();
            if (c == 0) chk("r0_start", mif.md_start, 1);
            chk("r0_busy", mif.md_busy, (c >= 1 && c <= 4));
            chk("r0_nowb", mif.md_wb_req, 0);
            chk("r0_nostall", PC_write, 1);
            tick();
        end

        // reset during BUSY, restart, reset during WB
        quiet();
        IFID_rs = 4;
        for (int c = 0; c <= 18; c++) begin
            IDEX_md_valid = (c == 0 || c == 11);
            IDEX_md_op = (c == 0);
            IDEX_rd = (c < 11) ? 5'd4 : 5'd6;
            rst = (c == 10 || c == 17);
            at_neg();
            if (c == 11 || c == 18) begin
                chk("rmid_busy", mif.md_busy, 0);
                chk("rmid_wbreq", mif.md_wb_req, 0);
                chk("rmid_pcw", PC_write, 1);
                chk("rmid_cnt", stall_cnt, 0);
            end
            if (c == 11) chk("rmid_restart", mif.md_start, 1);
            if (c == 15) chk("rmid_lat", {mif.md_busy, mif.md_wb_req}, 2'b10);
            if (c == 16)
                chk("rmid_wb", {mif.md_wb_req, mif.md_wb_rd}, {1'b1, 5'd6});
            tick();
        end
        rst = 1'b0;

        // randomized traffic
        quiet();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            IFID_rs = 5'($urandom_range(0, 3));
            IFID_rt = 5'($urandom_range(0, 3));
            IFID_rd = 5'($urandom_range(0, 3));
            IFID_regwrite = 1'($urandom_range(0, 1));
            IFID_md = ($urandom_range(0, 3) == 0);
            ex_flush = ($urandom_range(0, 3) == 0);
            IDEX_md_valid = m_act ? (ex_flush && $urandom_range(0, 1) == 1)
                                  : ($urandom_range(0, 2) == 0);
            IDEX_md_op = ($urandom_range(0, 3) == 0);
            IDEX_rd = 5'($urandom_range(0, 3));
            wb_ack = ($urandom_range(0, 2) == 0);
            tick();
        end
        rst = 1'b0;

        // saturation of the stall counter
        quiet();
        do_reset();
        IFID_rs = 9;
        IDEX_md_valid = 1; IDEX_md_op = 1; IDEX_rd = 9;
        tick();
        IDEX_md_valid = 0;
        for (int n = 0; n < 70000; n++) tick();
        at_neg();
        chk("sat_cnt", stall_cnt, 16'hFFFF);
        chk("sat_stall", mux_ctrl, 1);
        tick();
        do_reset();
        at_neg();
        chk("sat_rst_cnt", stall_cnt, 0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
